// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: WM8731 register map, power-up values and sequencer state encoding
// shared by the configuration sequencer and its table ROM.
package codec_cfg_pkg;

    localparam logic [6:0] REG_R0  = 7'd0;
    localparam logic [6:0] REG_R1  = 7'd1;
    localparam logic [6:0] REG_R2  = 7'd2;
    localparam logic [6:0] REG_R3  = 7'd3;
    localparam logic [6:0] REG_R4  = 7'd4;
    localparam logic [6:0] REG_R5  = 7'd5;
    localparam logic [6:0] REG_R6  = 7'd6;
    localparam logic [6:0] REG_R7  = 7'd7;
    localparam logic [6:0] REG_R8  = 7'd8;
    localparam logic [6:0] REG_R9  = 7'd9;
    localparam logic [6:0] REG_R15 = 7'd15;

    localparam logic [8:0] VAL_RESET      = 9'h000;
    localparam logic [8:0] VAL_PWR_ON     = 9'h000;
    localparam logic [8:0] VAL_LINE_IN    = 9'h017;
    localparam logic [8:0] VAL_APATH_LINE = 9'h012;
    localparam logic [8:0] VAL_APATH_MIC  = 9'h015;
    localparam logic [8:0] VAL_DPATH      = 9'h000;
    localparam logic [8:0] VAL_IFACE      = 9'h001;
    localparam logic [8:0] VAL_SAMPLE     = 9'h000;
    localparam logic [8:0] VAL_ACTIVE     = 9'h001;
    localparam logic [1:0] HP_CTRL        = 2'b01;

    localparam int         TABLE_LEN = 11;
    localparam logic [3:0] IDX_R2    = 4'd4;
    localparam logic [3:0] IDX_R3    = 4'd5;
    localparam logic [3:0] IDX_R4    = 4'd6;

    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_RELEASE  = 3'd3;
    localparam logic [2:0] S_RETRY    = 3'd4;
    localparam logic [2:0] S_IDLE     = 3'd5;

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: power-up table index -> {reg_addr, reg_val}; run-time rewrites
// reuse the R2/R3/R4 entries with the live volume and input selection.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  idx,
    input  logic [6:0]  volume,
    input  logic        sel_mic,
    output logic [15:0] word
);

    always_comb begin
        case (idx)
            4'd0:    word = {REG_R15, VAL_RESET};
            4'd1:    word = {REG_R6, VAL_PWR_ON};
            4'd2:    word = {REG_R0, VAL_LINE_IN};
            4'd3:    word = {REG_R1, VAL_LINE_IN};
            4'd4:    word = {REG_R2, HP_CTRL, volume};
            4'd5:    word = {REG_R3, HP_CTRL, volume};
            4'd6:    word = {REG_R4, sel_mic ? VAL_APATH_MIC : VAL_APATH_LINE};
            4'd7:    word = {REG_R5, VAL_DPATH};
            4'd8:    word = {REG_R7, VAL_IFACE};
            4'd9:    word = {REG_R8, VAL_SAMPLE};
            default: word = {REG_R9, VAL_ACTIVE};
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: writes the WM8731 power-up table over i2c, then serves
// volume-step and input-select rewrites with per-phase timeout and retry.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter logic [6:0] VOL_INIT    = 7'h79,
    parameter logic [6:0] VOL_MIN     = 7'h30,
    parameter logic [6:0] VOL_MAX     = 7'h7F,
    parameter int         START_DELAY = 1000,
    parameter int         TIMEOUT     = 4095,
    parameter int         RETRIES     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sel_mic,
    input  logic        vol_up,
    input  logic        end_tr,
    output logic        go,
    output logic [23:0] data,
    output logic        config_done,
    output logic        busy,
    output logic        error,
    output logic [6:0]  volume
);

    localparam int CW = $clog2((START_DELAY > TIMEOUT ? START_DELAY : TIMEOUT) + 1);
    localparam int RW = $clog2(RETRIES + 1);

    logic [2:0]    state_q, state_d, nxt_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d, nxt_idx;
    logic [RW-1:0] retry_q, retry_d;
    logic [23:0]   data_q, data_d;
    logic [6:0]    vol_q, vol_d;
    logic [2:0]    mic_sync_q, mic_sync_d;
    logic          go_q, go_d, done_q, done_d, nxt_done, err_q, err_d;
    logic          vol_pend_q, vol_pend_d, mic_pend_q, mic_pend_d;
    logic          vol_clr, mic_clr, timeout, last;
    logic [15:0]   rom_word;

    codec_cfg_rom u_rom (
        .idx     (idx_q),
        .volume  (vol_q),
        .sel_mic (mic_sync_q[1]),
        .word    (rom_word)
    );

    assign timeout    = cnt_q == CW'(TIMEOUT - 1);
    assign last       = idx_q == 4'(TABLE_LEN - 1);
    assign mic_sync_d = {mic_sync_q[1:0], sel_mic};
    // Bit 2 holds the previous synchronised level, so any edge raises a request
    assign mic_pend_d = (mic_sync_q[2] ^ mic_sync_q[1]) | (mic_pend_q & ~mic_clr);
    assign vol_pend_d = vol_up | (vol_pend_q & ~vol_clr);

    always_comb begin
        nxt_state = S_IDLE;
        nxt_idx   = idx_q;
        nxt_done  = done_q;
        if (!done_q) begin
            nxt_state = last ? S_IDLE : S_LOAD;
            nxt_idx   = last ? idx_q : idx_q + 4'd1;
            nxt_done  = last;
        end else if (idx_q == IDX_R2) begin
            nxt_state = S_LOAD;
            nxt_idx   = IDX_R3;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        retry_d = retry_q;
        go_d    = go_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
        vol_d   = vol_q;
        vol_clr = 1'b0;
        mic_clr = 1'b0;
        case (state_q)
            S_PWR_WAIT: state_d = (cnt_q == CW'(START_DELAY - 1)) ? S_LOAD : S_PWR_WAIT;
            S_LOAD: begin
                data_d  = {DEV_ADDR, rom_word};
                retry_d = '0;
                cnt_d   = '0;
                state_d = S_ISSUE;
                mic_clr = done_q && idx_q == IDX_R4;
            end
            S_ISSUE: begin
                // go only rises once end_tr is low; waiting for that eats into the timeout
                go_d    = (go_q && end_tr) || timeout ? 1'b0 : go_q | ~end_tr;
                state_d = go_q && end_tr ? S_RELEASE : timeout ? S_RETRY : S_ISSUE;
                cnt_d   = go_q && end_tr ? '0 : cnt_q + CW'(1);
            end
            S_RELEASE: begin
                state_d = !end_tr ? nxt_state : timeout ? S_RETRY : S_RELEASE;
                idx_d   = !end_tr ? nxt_idx : idx_q;
                done_d  = !end_tr ? nxt_done : done_q;
            end
            S_RETRY: begin
                cnt_d = '0;
                if (int'(retry_q) < RETRIES) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    state_d = nxt_state;
                    idx_d   = nxt_idx;
                    done_d  = nxt_done;
                end
            end
            S_IDLE: begin
                if (mic_pend_q) begin
                    idx_d   = IDX_R4;
                    state_d = S_LOAD;
                end else if (vol_pend_q) begin
                    idx_d   = IDX_R2;
                    vol_d   = (vol_q == VOL_MAX) ? VOL_MIN : vol_q + 7'd1;
                    vol_clr = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PWR_WAIT;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            go_q       <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vol_q      <= VOL_INIT;
            mic_sync_q <= '0;
            vol_pend_q <= 1'b0;
            mic_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            go_q       <= go_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            vol_q      <= vol_d;
            mic_sync_q <= mic_sync_d;
            vol_pend_q <= vol_pend_d;
            mic_pend_q <= mic_pend_d;
        end
    end

    assign go          = go_q;
    assign data        = data_q;
    assign config_done = done_q;
    assign error       = err_q;
    assign volume      = vol_q;
    assign busy        = state_q != S_IDLE || vol_pend_q || mic_pend_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb_codec_config_sequencer: i2c responder plus write scoreboard around the
// codec configuration sequencer.
`timescale 1ns/1ps
module tb_codec_config_sequencer;

    localparam int TIMEOUT = 4095;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_mic = 1'b0;
    logic        vol_up = 1'b0;
    logic        end_tr = 1'b0;
    logic        go, config_done, busy, error;
    logic [23:0] data;
    logic [6:0]  volume;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    logic [23:0] exp_q[$];
    int          rise_t[$];
    logic [23:0] mon_exp;
    bit          model_on = 1'b1;
    logic        go_prev = 1'b0;

    codec_config_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sel_mic     (sel_mic),
        .vol_up      (vol_up),
        .end_tr      (end_tr),
        .go          (go),
        .data        (data),
        .config_done (config_done),
        .busy        (busy),
        .error       (error),
        .volume      (volume)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // i2c stand-in: end_tr rises 20 cycles after go, falls 5 cycles after go drops
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            end_tr <= 1'b0;
            hi_cnt <= 0;
            lo_cnt <= 0;
        end else begin
            hi_cnt <= (go && !end_tr && model_on) ? hi_cnt + 1 : 0;
            lo_cnt <= (!go && end_tr) ? lo_cnt + 1 : 0;
            if (go && !end_tr && model_on && hi_cnt == 19) end_tr <= 1'b1;
            if (!go && end_tr && lo_cnt == 4) end_tr <= 1'b0;
        end
    end

    // Every go rising edge is one write attempt; its data must match the queue head
    always @(negedge clock) begin
        if (go && !go_prev) begin
            rise_t.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got=%h required=<none>", data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL write_data got=%h required=%h", data, mon_exp);
                end
            end
        end
        go_prev = go;
    end

    function automatic logic [23:0] tbl(input int i, input logic [6:0] v, input logic m);
        logic [15:0] w;
        case (i)
            0:       w = {7'd15, 9'h000};
            1:       w = {7'd6, 9'h000};
            2:       w = {7'd0, 9'h017};
            3:       w = {7'd1, 9'h017};
            4:       w = {7'd2, 2'b01, v};
            5:       w = {7'd3, 2'b01, v};
            6:       w = {7'd4, m ? 9'h015 : 9'h012};
            7:       w = {7'd5, 9'h000};
            8:       w = {7'd7, 9'h001};
            9:       w = {7'd8, 9'h000};
            default: w = {7'd9, 9'h001};
        endcase
        return {8'h34, w};
    endfunction

    task automatic push_table(input logic [6:0] v, input logic m);
        for (int i = 0; i < 11; i++) exp_q.push_back(tbl(i, v, m));
    endtask

    task automatic pulse_vol();
        @(negedge clock);
        vol_up = 1'b1;
        @(negedge clock);
        vol_up = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max) begin
            @(negedge clock);
            n++;
        end
        ok = n < max;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sel_mic = 1'b0;
        vol_up  = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++; if (go !== 1'b0) begin n_fail++; $display("FAIL reset_go got=%b required=0", go); end
        n_tests++; if (data !== 24'h0) begin n_fail++; $display("FAIL reset_data got=%h required=000000", data); end
        n_tests++; if (config_done !== 1'b0) begin n_fail++; $display("FAIL reset_config_done got=%b required=0", config_done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b required=1", busy); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b required=0", error); end
        n_tests++; if (volume !== 7'h79) begin n_fail++; $display("FAIL reset_volume got=%h required=79", volume); end
        push_table(7'h79, 1'b0);
        rise_t.delete();
        rel_cyc = cyc;
        reset_n = 1'b1;
    endtask

    task automatic test_power_up();
        bit ok;
        wait_idle(5000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL powerup_drain got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL powerup_config_done got=%b required=1", config_done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL powerup_busy got=%b required=0", busy); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL powerup_error got=%b required=0", error); end
        n_tests++;
        if (rise_t.size() < 1 || rise_t[0] - rel_cyc < 1000 || rise_t[0] - rel_cyc > 1004) begin
            n_fail++;
            $display("FAIL powerup_start_delay got=%0d required=1000..1004", rise_t.size() > 0 ? rise_t[0] - rel_cyc : -1);
        end
    endtask

    task automatic test_vol_up();
        bit ok;
        exp_q.push_back(24'h3404FA);
        exp_q.push_back(24'h3406FA);
        pulse_vol();
        wait_idle(1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL volup_drain got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (volume !== 7'h7A) begin n_fail++; $display("FAIL volup_volume got=%h required=7a", volume); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [6:0] v = 7'h7A;
        while (v != 7'h7F) begin
            v = v + 7'd1;
            exp_q.push_back(tbl(4, v, 1'b0));
            exp_q.push_back(tbl(5, v, 1'b0));
            pulse_vol();
            wait_idle(1000, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_step_drain got=%0d_left required=0", exp_q.size()); end
        end
        n_tests++; if (volume !== 7'h7F) begin n_fail++; $display("FAIL wrap_at_max got=%h required=7f", volume); end
        exp_q.push_back(24'h3404B0);
        exp_q.push_back(24'h3406B0);
        pulse_vol();
        wait_idle(1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_drain got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (volume !== 7'h30) begin n_fail++; $display("FAIL wrap_volume got=%h required=30", volume); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        exp_q.push_back(tbl(4, 7'h31, 1'b0));
        exp_q.push_back(tbl(5, 7'h31, 1'b0));
        exp_q.push_back(tbl(4, 7'h32, 1'b0));
        exp_q.push_back(tbl(5, 7'h32, 1'b0));
        pulse_vol();
        while (!go && n < 200) begin @(negedge clock); n++; end
        repeat (3) pulse_vol();
        wait_idle(2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_drain got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (volume !== 7'h32) begin n_fail++; $display("FAIL b2b_volume got=%h required=32", volume); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        exp_q.push_back(tbl(4, 7'h33, 1'b0));
        pulse_vol();
        while (!go && n < 200) begin @(negedge clock); n++; end
        n_tests++; if (go !== 1'b1) begin n_fail++; $display("FAIL midreset_go_seen got=%b required=1", go); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (go !== 1'b0) begin n_fail++; $display("FAIL midreset_go_async got=%b required=0", go); end
        n_tests++; if (volume !== 7'h79) begin n_fail++; $display("FAIL midreset_volume got=%h required=79", volume); end
        exp_q.delete();
        repeat (3) @(negedge clock);
        push_table(7'h79, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic test_mic_during_init();
        bit ok;
        int n = 0;
        while (!(go && data == tbl(8, 7'h79, 1'b0)) && n < 5000) begin @(negedge clock); n++; end
        n_tests++; if (n >= 5000) begin n_fail++; $display("FAIL mic_r7_seen got=%h required=%h", data, tbl(8, 7'h79, 1'b0)); end
        sel_mic = 1'b1;
        exp_q.push_back(24'h340815);
        wait_idle(5000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mic_drain got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL mic_config_done got=%b required=1", config_done); end
        repeat (50) @(negedge clock);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mic_busy got=%b required=0", busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        reset_n  = 1'b0;
        sel_mic  = 1'b0;
        model_on = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        repeat (4) exp_q.push_back(tbl(0, 7'h79, 1'b0));
        for (int i = 1; i < 11; i++) exp_q.push_back(tbl(i, 7'h79, 1'b0));
        rise_t.delete();
        reset_n = 1'b1;
        while (!error && n < 25000) begin @(negedge clock); n++; end
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error got=%b required=1", error); end
        n_tests++; if (rise_t.size() != 4) begin n_fail++; $display("FAIL timeout_attempts got=%0d required=4", rise_t.size()); end
        for (int k = 1; k < 4 && k < rise_t.size(); k++) begin
            n_tests++;
            if (rise_t[k] - rise_t[k-1] < TIMEOUT || rise_t[k] - rise_t[k-1] > TIMEOUT + 2) begin
                n_fail++;
                $display("FAIL timeout_spacing got=%0d required=%0d..%0d", rise_t[k] - rise_t[k-1], TIMEOUT, TIMEOUT + 2);
            end
        end
        model_on = 1'b1;
        wait_idle(5000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_continue got=%0d_left required=0", exp_q.size()); end
        n_tests++; if (config_done !== 1'b1) begin n_fail++; $display("FAIL timeout_config_done got=%b required=1", config_done); end
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error_sticky got=%b required=1", error); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_vol_up();
        test_wrap();
        test_back_to_back();
        test_reset_mid_write();
        test_mic_during_init();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Sequences all WM8731 codec register writes over the existing i2c serial control module.
- Issues the power-up configuration table, then serves run-time rewrites: volume-up requests from keytr and line/mic input-select changes.
- Runs on the 1 MHz control clock that also drives i2c.
- Drives i2c GO/I2C_DATA and consumes END_TR, replacing the ad-hoc configuration logic inside CLOCK_500.

Parameters:
- DEV_ADDR, 8'h34, codec write address byte placed in data[23:16].
- VOL_INIT, 7'h79, headphone volume written at power-up.
- VOL_MIN, 7'h30, volume after wrap.
- VOL_MAX, 7'h7F, highest volume before wrap.
- START_DELAY, 1000, clock cycles from reset release to the first write.
- TIMEOUT, 4095, maximum cycles to wait for end_tr per phase.
- RETRIES, 3, re-attempts per write before error.

Ports:
- clock  input  1  1 MHz control clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sel_mic  input  1  0 = line-in, 1 = microphone; level, synchronised internally with a 2-flop synchroniser.
- vol_up  input  1  volume-step request; one-cycle pulse (KEYON).
- end_tr  input  1  i2c transfer-complete flag.
- go  output  1  start request to i2c.
- data  output  24  {DEV_ADDR, reg_addr[6:0], reg_val[8:0]}.
- config_done  output  1  power-up table fully written.
- busy  output  1  a write is in progress or pending.
- error  output  1  sticky; a write exhausted its retries.
- volume  output  7  current headphone volume code.

Behaviour:
- Reset values:
  - go=0, data=0, config_done=0, busy=1, error=0, volume=VOL_INIT.
  - Pending flags cleared, table index=0, state=PWR_WAIT.
  - Asserting reset_n low mid-transfer aborts immediately: go drops asynchronously.
- Power-up table, in order (reg:value):
  - R15:000 (reset), R6:000 (power on).
  - R0:017, R1:017 (line-in gain).
  - R2:{2'b01,volume}, R3:{2'b01,volume}.
  - R4:012 if sel_mic=0, else 015.
  - R5:000, R7:001, R8:000, R9:001 (active).
  - 11 writes total.
- States:
  - PWR_WAIT: count START_DELAY cycles, then go to LOAD.
  - LOAD: register data from the table or pending request (1 cycle); go stays 0.
  - ISSUE: go=1; wait for end_tr=1, then RELEASE. If TIMEOUT expires, go to RETRY.
  - RELEASE: go=0; wait for end_tr=0, then next step. If TIMEOUT expires, go to RETRY.
  - RETRY: go=0 for one cycle.
    - Retry count < RETRIES: increment count, return to ISSUE.
    - Otherwise: set error, skip this write, take the next step.
  - Next step after a write:
    - During init: index++. After index 10, set config_done=1 and enter IDLE.
    - After run-time writes: return to IDLE or LOAD.
  - IDLE: busy=0. Leave when a pending flag is set.
- Handshake rules:
  - data stays stable from LOAD until RELEASE exits.
  - go is never raised while end_tr=1. If end_tr is already high when ISSUE is entered, hold go=0 until it falls; this counts toward the timeout.
- Run-time requests:
  - vol_up pulse sets vol_pend.
  - A change of the synchronised sel_mic sets mic_pend.
  - Both are latched in any state, including during init and mid-write; nothing is lost.
  - Multiple vol_up pulses before service coalesce into one step.
  - Requests arriving during init are served after config_done.
  - Priority in IDLE: mic_pend > vol_pend.
  - Simultaneous set and service of the same flag leaves the flag set.
- Volume service:
  - Update on entering the R2 write: volume = (volume==VOL_MAX) ? VOL_MIN : volume+1.
  - Write R2 then R3 with the same value; clear vol_pend at the start of R2.
- Mic service:
  - Write R4 with the current synchronised sel_mic value.
  - Clear mic_pend at LOAD, so a toggle during the write re-triggers service.
- busy = 1 whenever state != IDLE or any pending flag is set.

Decomposition:
- Package codec_cfg_pkg:
  - WM8731 register address constants (R0..R9, R15) and default value constants.
  - State enum, table length constant (11).
- Sub-module codec_cfg_rom: combinational index -> {reg_addr, reg_val}, with volume and sel_mic as inputs.
- Sequencer FSM, counters and pending logic stay in the top.

Test Plan:
- Reset release with an i2c model (end_tr high 20 cycles after go, low 5 cycles after go drops) -> 11 writes in table order; first data = 24'h341E00 after 1000 cycles; then config_done=1, busy=0.
- vol_up pulse in IDLE with volume=7'h79 -> writes data 24'h3404FA then 24'h3406FA; volume=7'h7A.
- volume=7'h7F, vol_up -> wraps to 7'h30; R2 data = 24'h3404B0.
- sel_mic 0->1 during the R7 init write -> after config_done, exactly one extra R4 write with data 24'h340815.
- Model never asserts end_tr -> 4 attempts spaced by TIMEOUT; error=1; sequence continues to the next table entry.
- reset_n low while go=1 mid-write -> go=0 immediately; after release, the table restarts from R15.
